// File: rtl/xceiver_245_ctl.sv
// Break-before-make sequencer for one 74x245 transceiver shared by two
// requesters (AB: A drives B, dir=1; BA: B drives A, dir=0).
// Round-robin arbitration, registered nen/dir/grant outputs, and a
// programmable dead time after every release.
// Optional feature macro: XCVR_CTL_TIMEOUT_EN (burst pre-emption after
// MAX_BURST enabled cycles when the other requester is waiting).
module xceiver_245_ctl #(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 16
) (
  input  logic clk,
  input  logic nreset,
  input  logic req_ab,
  input  logic req_ba,
  output logic gnt_ab,
  output logic gnt_ba,
  output logic nen,
  output logic dir,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACTIVE,
    S_RELEASE,
    S_GAP
  } state_t;

  // GAP is entered with TURN_CYCLES-1 and left on the cycle the counter is 0,
  // giving TURN_CYCLES cycles in GAP.
  localparam logic [3:0] GAP_LOAD = 4'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);

  if (TURN_CYCLES < 0 || TURN_CYCLES > 15) begin : g_turn_range
    $error("xceiver_245_ctl: TURN_CYCLES must be 0..15");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_burst_range
    $error("xceiver_245_ctl: MAX_BURST must be 1..255");
  end

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic       last_ab_q, last_ab_d;   // 1: AB won last arbitration, 0: BA
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       nen_q, gnt_ab_q, gnt_ba_q, busy_q;

  logic win_ab;
  logic any_req;
  logic own_req;
  logic arbitrate;

`ifdef XCVR_CTL_TIMEOUT_EN
  localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);
  logic [7:0] burst_q, burst_d;
  logic       other_req;
  logic       preempt;
`endif

  // Next-state, direction and arbitration logic.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    last_ab_d = last_ab_q;
    gap_cnt_d = gap_cnt_q;
    arbitrate = 1'b0;
    win_ab    = req_ab & (~req_ba | ~last_ab_q);
    any_req   = req_ab | req_ba;
    own_req   = dir_q ? req_ab : req_ba;
`ifdef XCVR_CTL_TIMEOUT_EN
    burst_d   = burst_q;
    other_req = dir_q ? req_ba : req_ab;
    preempt   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: arbitrate = 1'b1;
      S_SETUP: begin
        // Winner gave up during setup: abort with nen never asserted.
        if (own_req) begin
          state_d = S_ACTIVE;
`ifdef XCVR_CTL_TIMEOUT_EN
          burst_d = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
`ifdef XCVR_CTL_TIMEOUT_EN
        if (burst_q != 8'hFF) burst_d = burst_q + 8'd1;
        // burst_q counts completed enabled cycles; this cycle is number burst_q+1.
        preempt = other_req && (({1'b0, burst_q} + 9'd1) >= BURST_LIM);
        if (!own_req || preempt) state_d = S_RELEASE;
`else
        if (!own_req) state_d = S_RELEASE;
`endif
      end
      S_RELEASE: begin
        if (TURN_CYCLES == 0) begin
          arbitrate = 1'b1;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) arbitrate = 1'b1;
        else gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // The IDLE decision is also taken on the last dead-time cycle, so a
    // waiting requester goes straight to SETUP and consecutive enables are
    // separated by exactly TURN_CYCLES+2 disabled cycles.
    if (arbitrate) begin
      if (any_req) begin
        state_d   = S_SETUP;
        dir_d     = win_ab;
        last_ab_d = win_ab;
      end else begin
        state_d   = S_IDLE;
      end
    end
  end

  // State, direction and registered pin outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      last_ab_q <= 1'b0;
      gap_cnt_q <= 4'd0;
      nen_q     <= 1'b1;
      gnt_ab_q  <= 1'b0;
      gnt_ba_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      last_ab_q <= last_ab_d;
      gap_cnt_q <= gap_cnt_d;
      nen_q     <= (state_d != S_ACTIVE);
      gnt_ab_q  <= (state_d == S_ACTIVE) & dir_d;
      gnt_ba_q  <= (state_d == S_ACTIVE) & ~dir_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

`ifdef XCVR_CTL_TIMEOUT_EN
  // Enabled-cycle counter for the current grant.
  always_ff @(posedge clk) begin
    if (!nreset) burst_q <= 8'd0;
    else         burst_q <= burst_d;
  end
`endif

  assign nen    = nen_q;
  assign dir    = dir_q;
  assign gnt_ab = gnt_ab_q;
  assign gnt_ba = gnt_ba_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_xceiver_245_ctl.sv
// Bench for xceiver_245_ctl: reset, abort, random single/contended transfers
// scored against a round-robin transaction model, turnaround-zero alternation
// and (with XCVR_CTL_TIMEOUT_EN) burst pre-emption.
module tb_xceiver_245_ctl;

  localparam int TURN  = 2;
  localparam int TURN0 = 0;
  localparam int MB2   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst1, ab1, ba1, gab1, gba1, nen1, dir1, busy1;
  logic nrst2, ab2, ba2, gab2, gba2, nen2, dir2, busy2;

  xceiver_245_ctl #(.TURN_CYCLES(TURN), .MAX_BURST(16)) dut1 (
    .clk(clk), .nreset(nrst1), .req_ab(ab1), .req_ba(ba1),
    .gnt_ab(gab1), .gnt_ba(gba1), .nen(nen1), .dir(dir1), .busy(busy1));

  xceiver_245_ctl #(.TURN_CYCLES(TURN0), .MAX_BURST(MB2)) dut2 (
    .clk(clk), .nreset(nrst2), .req_ab(ab2), .req_ba(ba2),
    .gnt_ab(gab2), .gnt_ba(gba2), .nen(nen2), .dir(dir2), .busy(busy2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, req);
  endtask

  task automatic check_ok(input string nm, input bit ok, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, req);
  endtask

  // Expected grant: direction, granted cycles, disabled cycles before it (-1 = any).
  typedef struct { bit d; int len; int gap; } exp_t;
  exp_t sbq[$];
  bit   mlast_ab;   // model: last arbitration winner was AB

  // ---------------- monitor / scoreboard for dut1 ----------------
  bit   mon_en = 1'b0;
  logic p_nen1 = 1'b1, p_dir1 = 1'b0;
  bit   have_prev1 = 1'b0;
  int   gap1 = 0, len1 = 0;
  exp_t cur1;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("gnt_ab_def", int'(gab1), int'(!nen1 && dir1));
      check_eq("gnt_ba_def", int'(gba1), int'(!nen1 && !dir1));
      check_ok("busy_when_enabled", nen1 || busy1, busy1, 1);
      if (dir1 != p_dir1) check_ok("dir_change_while_disabled", p_nen1 && nen1, nen1, 1);
      if (p_nen1 && !nen1) begin
        if (have_prev1) check_ok("gap_min", gap1 >= TURN + 2, gap1, TURN + 2);
        if (sbq.size() == 0) begin
          check_ok("unexpected_grant", 1'b0, dir1, -1);
          cur1.len = -1;
        end else begin
          cur1 = sbq.pop_front();
          check_eq("grant_dir", dir1, cur1.d);
          if (cur1.gap >= 0) check_eq("grant_gap", gap1, cur1.gap);
        end
        len1 = 1;
      end else if (!nen1) begin
        len1++;
      end else if (!p_nen1 && nen1) begin
        if (cur1.len >= 0) check_eq("grant_len", len1, cur1.len);
        have_prev1 = 1'b1;
        gap1 = 1;
      end else begin
        gap1++;
      end
    end
    p_nen1 = nen1;
    p_dir1 = dir1;
  end

  // ---------------- monitor for dut2 (turnaround zero) ----------------
  bit   mon2_en = 1'b0;
  logic p_nen2 = 1'b1, p_dir2 = 1'b0, en_dir2 = 1'b0;
  bit   have2 = 1'b0;
  int   gap2 = 0, n2_en = 0;

  always @(negedge clk) begin
    if (mon2_en) begin
      check_eq("t0_gnt_ab_def", int'(gab2), int'(!nen2 && dir2));
      check_eq("t0_gnt_ba_def", int'(gba2), int'(!nen2 && !dir2));
      if (dir2 != p_dir2) check_ok("t0_dir_change_while_disabled", p_nen2 && nen2, nen2, 1);
      if (p_nen2 && !nen2) begin
        if (have2) begin
          check_eq("t0_gap", gap2, TURN0 + 2);
          check_ok("t0_alternate", dir2 != en_dir2, dir2, int'(!en_dir2));
        end
        en_dir2 = dir2;
        have2 = 1'b1;
        n2_en++;
      end
      if (!p_nen2 && nen2) gap2 = 1;
      else if (nen2) gap2++;
    end else begin
      have2 = 1'b0;
    end
    p_nen2 = nen2;
    p_dir2 = dir2;
  end

  // ---------------- drivers ----------------
  task automatic set1(input bit a, input logic v);
    if (a) ab1 = v; else ba1 = v;
  endtask
  task automatic set2(input bit a, input logic v);
    if (a) ab2 = v; else ba2 = v;
  endtask
  function automatic logic g1(input bit a);
    return a ? gab1 : gba1;
  endfunction
  function automatic logic g2(input bit a);
    return a ? gab2 : gba2;
  endfunction

  // Requester on dut1: raise, wait for grant, hold for len granted cycles, drop.
  task automatic agent1(input bit a, input int len, input int exp_lat);
    int w, seen, h;
    set1(a, 1'b1);
    w = 0;
    while (!g1(a) && w < 200) begin
      @(posedge clk); #1;
      w++;
      if (exp_lat > 0 && w == 1) begin
        check_eq("setup_dir", dir1, a);
        check_eq("setup_nen", nen1, 1);
      end
    end
    check_ok("grant_wait", g1(a), w, 200);
    if (exp_lat > 0) check_eq("grant_latency", w, exp_lat);
    seen = 1; h = 0;
    while (seen < len && h < 300) begin
      @(posedge clk); #1;
      h++;
      if (g1(a)) seen++;
    end
    set1(a, 1'b0);
  endtask

  task automatic agent2(input bit a, input int n, input int len);
    int w, seen;
    for (int k = 0; k < n; k++) begin
      set2(a, 1'b1);
      w = 0;
      while (!g2(a) && w < 200) begin @(posedge clk); #1; w++; end
      check_ok("t0_grant_wait", g2(a), w, 200);
      seen = 1;
      while (seen < len && w < 400) begin
        @(posedge clk); #1;
        w++;
        if (g2(a)) seen++;
      end
      set2(a, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle1();
    int w = 0;
    while (busy1 && w < 100) begin @(posedge clk); #1; w++; end
    check_ok("idle_reached", !busy1, busy1, 0);
  endtask

  task automatic wait_idle2();
    int w = 0;
    while (busy2 && w < 100) begin @(posedge clk); #1; w++; end
    check_ok("t0_idle_reached", !busy2, busy2, 0);
  endtask

  // One transaction set from idle: 0 = AB only, 1 = BA only, 2 = both at once.
  task automatic scenario(input int kind, input int la, input int lb);
    exp_t e;
    bit   fab;
    int   k;
    if (kind == 0) begin
      e.d = 1'b1; e.len = la; e.gap = -1; sbq.push_back(e);
      mlast_ab = 1'b1;
      agent1(1'b1, la, 2);
    end else if (kind == 1) begin
      e.d = 1'b0; e.len = lb; e.gap = -1; sbq.push_back(e);
      mlast_ab = 1'b0;
      agent1(1'b0, lb, 2);
    end else begin
      fab = !mlast_ab;
      e.d = fab;  e.len = fab ? la : lb; e.gap = -1;       sbq.push_back(e);
      e.d = !fab; e.len = fab ? lb : la; e.gap = TURN + 2; sbq.push_back(e);
      mlast_ab = !fab;
      fork
        agent1(1'b1, la, fab ? 2 : 0);
        agent1(1'b0, lb, fab ? 0 : 2);
      join
    end
    wait_idle1();
    k = $urandom_range(0, 3);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst1 = 1'b0; ab1 = 1'b1; ba1 = 1'b0;
    nrst2 = 1'b0; ab2 = 1'b0; ba2 = 1'b0;

    // Reset with a request present.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_nen", nen1, 1);
    check_eq("rst_dir", dir1, 0);
    check_eq("rst_gnt_ab", gab1, 0);
    check_eq("rst_gnt_ba", gba1, 0);
    check_eq("rst_busy", busy1, 0);
    nrst1 = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_dir", dir1, 1);
    check_eq("rel_nen_setup", nen1, 1);
    @(posedge clk); #1;
    check_eq("rel_nen_active", nen1, 0);
    check_eq("rel_gnt_ab", gab1, 1);

    // Reset mid-transfer; afterwards AB must win a tie again.
    ba1 = 1'b1; nrst1 = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_nen", nen1, 1);
    check_eq("midrst_gnt_ab", gab1, 0);
    check_eq("midrst_dir", dir1, 0);
    check_eq("midrst_busy", busy1, 0);
    nrst1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("tie_after_rst_ab", gab1, 1);
    check_eq("tie_after_rst_ba", gba1, 0);
    ab1 = 1'b0; ba1 = 1'b0;
    wait_idle1();
    mlast_ab = 1'b1;
    mon_en = 1'b1;

    // Single transfer of 5 granted cycles, then contention 3/3.
    scenario(0, 5, 1);
    scenario(2, 3, 3);

    // Abort: one-cycle BA pulse in IDLE.
    ba1 = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_busy_setup", busy1, 1);
    check_eq("abort_nen_setup", nen1, 1);
    check_eq("abort_dir", dir1, 0);
    ba1 = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_busy_idle", busy1, 0);
    check_eq("abort_nen_idle", nen1, 1);
    check_eq("abort_gnt_ba", gba1, 0);
    mlast_ab = 1'b0;

    for (int s = 0; s < 20; s++)
      scenario($urandom_range(0, 2), $urandom_range(1, 8), $urandom_range(1, 8));
    repeat (3) begin @(posedge clk); #1; end
    check_eq("sb_drained", sbq.size(), 0);
    mon_en = 1'b0;

    // Turnaround zero: alternating requesters on dut2.
    nrst2 = 1'b1;
    mon2_en = 1'b1;
    fork
      agent2(1'b1, 3, 3);
      agent2(1'b0, 3, 3);
    join
    wait_idle2();
    check_eq("t0_enables", n2_en, 6);

`ifdef XCVR_CTL_TIMEOUT_EN
    begin
      int r, w, h;
      mon2_en = 1'b0;
      @(posedge clk); #1;
      mon2_en = 1'b1;
      ab2 = 1'b1; ba2 = 1'b1;
      w = 0;
      while (!gab2 && w < 20) begin @(posedge clk); #1; w++; end
      check_ok("to_first_ab", gab2, w, 20);
      r = 1;
      while (gab2 && r < 50) begin @(posedge clk); #1; if (gab2) r++; end
      check_eq("to_preempt_len", r, MB2);
      w = 0;
      while (!gba2 && w < 20) begin @(posedge clk); #1; w++; end
      check_ok("to_then_ba", gba2, w, 20);
      ba2 = 1'b0;
      w = 0;
      while (!gab2 && w < 20) begin @(posedge clk); #1; w++; end
      check_ok("to_ab_again", gab2, w, 20);
      h = 0;
      repeat (25) begin @(posedge clk); #1; if (gab2) h++; end
      check_eq("to_hold_uncontended", h, 25);
      ab2 = 1'b0;
      wait_idle2();
    end
`endif
    mon2_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
